// File: rtl/johnson_decoder_chk.sv
// Johnson-code receive checker: decodes an N-stage Johnson code to index/one-hot,
// flags illegal codes and sequence skips, tracks lock and counts errors.
module johnson_decoder_chk #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERRW     = 8
) (
  input  logic                     clk,
  input  logic                     rs,
  input  logic [N-1:0]             code_in,
  input  logic                     code_valid,
  output logic [$clog2(2*N)-1:0]   idx_out,
  output logic [2*N-1:0]           onehot_out,
  output logic                     out_valid,
  output logic                     illegal,
  output logic                     skip,
  output logic                     locked,
  output logic [ERRW-1:0]          err_cnt
);

  localparam int W = $clog2(2*N);
  localparam int unsigned NU = N;
  localparam logic [W-1:0] IDX_LAST = W'(2*N-1);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_CHECK    = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic [1:0]      st_q, st_d;
  logic [3:0]      run_q, run_d;
  logic [W-1:0]    idx_q, idx_d;
  logic [2*N-1:0]  onehot_q, onehot_d;
  logic            out_valid_q, out_valid_d;
  logic            illegal_q, illegal_d;
  logic            skip_q, skip_d;
  logic [ERRW-1:0] err_q, err_d;

  logic [W-1:0] pop, dec_idx, nxt_idx;
  logic [N-1:0] lo_pat, hi_pat;
  logic         legal, is_hold, is_adv, bump;

  // Legal codes are a run of ones anchored at bit0 (MSB clear) or at bit N-1 (MSB set).
  always_comb begin
    pop    = '0;
    lo_pat = '0;
    hi_pat = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      pop = pop + W'(code_in[i]);
    end
    for (int unsigned i = 0; i < NU; i++) begin
      lo_pat[i] = (i < 32'(pop));
      hi_pat[i] = ((i + 32'(pop)) >= NU);
    end
    legal   = code_in[N-1] ? (code_in == hi_pat) : (code_in == lo_pat);
    dec_idx = code_in[N-1] ? (W'(2*N) - pop) : pop;
    nxt_idx = (idx_q == IDX_LAST) ? '0 : idx_q + W'(1);
    is_hold = (dec_idx == idx_q);
    is_adv  = (dec_idx == nxt_idx);
  end

  // idx_q doubles as the previous index: it only changes on legal samples.
  always_comb begin
    st_d        = st_q;
    run_d       = run_q;
    idx_d       = idx_q;
    onehot_d    = onehot_q;
    out_valid_d = code_valid;
    illegal_d   = 1'b0;
    skip_d      = 1'b0;
    bump        = 1'b0;
    if (code_valid) begin
      if (!legal) begin
        illegal_d = 1'b1;
        onehot_d  = '0;
        st_d      = ST_UNLOCKED;
        run_d     = '0;
        bump      = 1'b1;
      end else begin
        idx_d    = dec_idx;
        onehot_d = {{(2*N-1){1'b0}}, 1'b1} << dec_idx;
        if (st_q == ST_UNLOCKED) begin
          st_d  = ST_CHECK;
          run_d = '0;
        end else if (is_adv) begin
          if (st_q == ST_CHECK) begin
            run_d = run_q + 4'd1;
            if (run_q + 4'd1 == 4'(LOCK_CNT)) begin
              st_d = ST_LOCKED;
            end
          end
        end else if (!is_hold) begin
          skip_d = 1'b1;
          bump   = 1'b1;
          st_d   = ST_CHECK;
          run_d  = '0;
        end
      end
    end
    err_d = (bump && err_q != '1) ? err_q + ERRW'(1) : err_q;
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      st_q        <= ST_UNLOCKED;
      run_q       <= '0;
      idx_q       <= '0;
      onehot_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      skip_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      st_q        <= st_d;
      run_q       <= run_d;
      idx_q       <= idx_d;
      onehot_q    <= onehot_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      skip_q      <= skip_d;
      err_q       <= err_d;
    end
  end

  assign idx_out    = idx_q;
  assign onehot_out = onehot_q;
  assign out_valid  = out_valid_q;
  assign illegal    = illegal_q;
  assign skip       = skip_q;
  assign locked     = (st_q == ST_LOCKED);
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_johnson_decoder_chk.sv
// Bench for johnson_decoder_chk: directed plan plus random codes against a
// table-driven reference model; a second instance uses a 2-bit error counter.
module tb_johnson_decoder_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rs = 1'b1;
  logic       code_valid = 1'b0;
  logic [3:0] code_in = 4'b0000;

  logic [2:0] a_idx, b_idx;
  logic [7:0] a_oh, b_oh;
  logic       a_ov, a_ill, a_skip, a_lock, b_ov, b_ill, b_skip, b_lock;
  logic [7:0] a_err;
  logic [1:0] b_err;

  johnson_decoder_chk #(.N(4), .LOCK_CNT(4), .ERRW(8)) dut_a (
    .clk(clk), .rs(rs), .code_in(code_in), .code_valid(code_valid),
    .idx_out(a_idx), .onehot_out(a_oh), .out_valid(a_ov), .illegal(a_ill),
    .skip(a_skip), .locked(a_lock), .err_cnt(a_err));

  johnson_decoder_chk #(.N(4), .LOCK_CNT(4), .ERRW(2)) dut_b (
    .clk(clk), .rs(rs), .code_in(code_in), .code_valid(code_valid),
    .idx_out(b_idx), .onehot_out(b_oh), .out_valid(b_ov), .illegal(b_ill),
    .skip(b_skip), .locked(b_lock), .err_cnt(b_err));

  // Reference model state
  logic [3:0] tbl [8];
  int         e_idx, e_err, e_err2, m_mode, m_run;  // m_mode: 0 unlocked, 1 check, 2 locked
  logic [7:0] e_oh;
  logic       e_ov, e_ill, e_skip;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic [3:0] c);
    int k;
    if (r) begin
      e_idx = 0; e_oh = '0; e_ov = 0; e_ill = 0; e_skip = 0;
      e_err = 0; e_err2 = 0; m_mode = 0; m_run = 0;
      return;
    end
    e_ov = v; e_ill = 0; e_skip = 0;
    if (!v) return;
    k = -1;
    for (int j = 0; j < 8; j++) if (tbl[j] == c) k = j;
    if (k < 0) begin
      e_ill = 1; e_oh = '0; m_mode = 0; m_run = 0;
      if (e_err < 255) e_err++;
      if (e_err2 < 3) e_err2++;
      return;
    end
    if (m_mode == 0) begin
      m_mode = 1; m_run = 0;
    end else if (k == (e_idx + 1) % 8) begin
      if (m_mode == 1) begin
        m_run++;
        if (m_run == 4) m_mode = 2;
      end
    end else if (k != e_idx) begin
      e_skip = 1; m_mode = 1; m_run = 0;
      if (e_err < 255) e_err++;
      if (e_err2 < 3) e_err2++;
    end
    e_idx = k;
    e_oh = 8'(1 << k);
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] c);
    @(negedge clk);
    rs = r; code_valid = v; code_in = c;
    @(posedge clk);
    model(r, v, c);
    #1;
    vectors++;
    chk("idx", 32'(a_idx), 32'(e_idx));
    chk("onehot", 32'(a_oh), 32'(e_oh));
    chk("out_valid", 32'(a_ov), 32'(e_ov));
    chk("illegal", 32'(a_ill), 32'(e_ill));
    chk("skip", 32'(a_skip), 32'(e_skip));
    chk("locked", 32'(a_lock), 32'(m_mode == 2));
    chk("err_cnt", 32'(a_err), 32'(e_err));
    chk("err_cnt_sat", 32'(b_err), 32'(e_err2));
    chk("b_idx", 32'(b_idx), 32'(e_idx));
    chk("b_flags", {28'd0, b_ov, b_ill, b_skip, b_lock},
        {28'd0, e_ov, e_ill, e_skip, logic'(m_mode == 2)});
  endtask

  initial begin
    logic [3:0] c;
    for (int k = 0; k < 8; k++)
      tbl[k] = (k <= 4) ? 4'((1 << k) - 1) : 4'(15 ^ ((1 << (k - 4)) - 1));
    model(1'b1, 1'b0, 4'b0);

    // Reset held with a valid code present
    step(1, 1, 4'b0111);
    step(1, 1, 4'b0111);
    chk("reset_err", 32'(a_err), 32'd0);

    // Full sequence with wrap; locks on the fifth sample
    foreach (tbl[k]) step(0, 1, tbl[k]);
    step(0, 1, 4'b0000);

    // Illegal while locked at idx 3, then re-acquire
    step(0, 1, 4'b0001); step(0, 1, 4'b0011); step(0, 1, 4'b0111);
    chk("locked_at3", 32'(a_lock), 32'd1);
    step(0, 1, 4'b0101);
    chk("illegal_hold_idx", 32'(a_idx), 32'd3);
    step(0, 1, 4'b1111);

    // Skip while locked at idx 2
    step(0, 1, 4'b1110); step(0, 1, 4'b1100); step(0, 1, 4'b1000);
    step(0, 1, 4'b0000); step(0, 1, 4'b0001); step(0, 1, 4'b0011);
    chk("locked_at2", 32'(a_lock), 32'd1);
    step(0, 1, 4'b1110);
    chk("skip_pulse", 32'(a_skip), 32'd1);
    step(0, 1, 4'b1100);

    // Holds interleaved with idle cycles
    step(0, 1, 4'b1000); step(0, 1, 4'b0000); step(0, 1, 4'b0001);
    step(0, 1, 4'b0011); step(0, 1, 4'b0111);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'b1010);
      step(0, 1, 4'b0111);
    end

    // Random mix of advances, holds, jumps, garbage, idles and rare resets
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)       c = tbl[(e_idx + 1) % 8];
      else if (sel == 6) c = tbl[e_idx];
      else if (sel == 7) c = tbl[$urandom_range(0, 7)];
      else               c = 4'($urandom_range(0, 15));
      step(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 9) < 8), c);
    end

    // Saturation of the narrow counter, then reset mid-stream
    step(1, 0, 4'b0000);
    step(0, 1, 4'b0101); step(0, 1, 4'b1010); step(0, 1, 4'b0110);
    step(0, 1, 4'b1001); step(0, 1, 4'b1011);
    chk("sat3", 32'(b_err), 32'd3);
    step(0, 1, 4'b0000); step(0, 1, 4'b0001); step(0, 1, 4'b0011);
    step(0, 1, 4'b0111); step(0, 1, 4'b1111);
    step(1, 1, 4'b1110);
    chk("reset_mid_lock", 32'(a_lock), 32'd0);
    step(0, 1, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
